// File: rtl/hilo_sequencer.sv
// Hi/Lo owner for the EX stage: launches the shared iterative multiplier/divider,
// stalls the pipeline until the result returns, and commits it into Hi/Lo.
module hilo_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        mul_validOut,
  input  logic        div_validOut,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        mul_validIn,
  output logic        div_validIn,
  output logic        mul_sign,
  output logic        div_sign,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        stall,
  output logic [31:0] Out,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        dz,
  output logic        err,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_WAIT = 2'd1, DIV_WAIT = 2'd2} state_t;

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;
  localparam logic [2:0] OP_MFHI = 3'b110;
  localparam logic [2:0] OP_MFLO = 3'b111;

  state_t        state_q, state_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   opa_q, opa_d, opb_q, opb_d;
  logic          mul_sign_q, mul_sign_d, div_sign_q, div_sign_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d, err_q, err_d;

  logic is_md, div_zero, in_wait, res_hit, timeout_hit;

  // Unit handshake: *_validIn is a one-cycle launch pulse in the first WAIT cycle
  // (cnt_q == 0); the unit answers with a one-cycle *_validOut carrying *_hi/*_lo.
  // A validOut from the other unit, or seen in IDLE, is not ours and is dropped.
  always_comb begin
    is_md       = op_valid && !op[2];
    div_zero    = is_md && op[1] && (SrcB == 32'd0);
    in_wait     = (state_q != IDLE);
    res_hit     = ((state_q == MUL_WAIT) && mul_validOut) ||
                  ((state_q == DIV_WAIT) && div_validOut);
    timeout_hit = in_wait && !res_hit && (cnt_q == CW'(TIMEOUT - 1));
    stall       = is_md && !(div_zero && !in_wait) && !res_hit && !flush && !timeout_hit;
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    mul_sign_d = mul_sign_q;
    div_sign_d = div_sign_q;
    cnt_d      = cnt_q;
    dz_d       = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !flush) begin
          if (div_zero) begin
            dz_d = 1'b1;
          end else if (is_md) begin
            opa_d = SrcA;
            opb_d = SrcB;
            cnt_d = '0;
            if (op[1]) begin
              div_sign_d = !op[0];
              state_d    = DIV_WAIT;
            end else begin
              mul_sign_d = !op[0];
              state_d    = MUL_WAIT;
            end
          end else if (op == OP_MTHI) begin
            hi_d = SrcA;
          end else if (op == OP_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      MUL_WAIT, DIV_WAIT: begin
        // Priority: flush kills the op even if the result arrives the same cycle.
        if (flush) begin
          state_d = IDLE;
        end else if (res_hit) begin
          hi_d    = (state_q == MUL_WAIT) ? mul_hi : div_hi;
          lo_d    = (state_q == MUL_WAIT) ? mul_lo : div_lo;
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      mul_sign_q <= 1'b0;
      div_sign_q <= 1'b0;
      cnt_q      <= '0;
      dz_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      mul_sign_q <= mul_sign_d;
      div_sign_q <= div_sign_d;
      cnt_q      <= cnt_d;
      dz_q       <= dz_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    mul_validIn = (state_q == MUL_WAIT) && (cnt_q == '0);
    div_validIn = (state_q == DIV_WAIT) && (cnt_q == '0);
    mul_sign    = mul_sign_q;
    div_sign    = div_sign_q;
    opA         = opa_q;
    opB         = opb_q;
    Hi          = hi_q;
    Lo          = lo_q;
    dz          = dz_q;
    err         = err_q;
    state_dbg   = state_q;
    Out         = '0;
    if (op_valid && (op == OP_MFHI)) Out = hi_q;
    else if (op_valid && (op == OP_MFLO)) Out = lo_q;
  end

endmodule
